// File: rtl/mem_pkg.sv
package mem_pkg;

  localparam int unsigned DEFAULT_DW       = 64;
  localparam int unsigned DEFAULT_MAX_WAIT = 16;
  localparam int unsigned REG_W            = 5;

  // Doubleword alignment: any set bit under this mask is a misaligned access.
  localparam logic [2:0] ALIGN_MASK = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_FAULT
  } state_e;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts ACCESS cycles without a memory acknowledge; done flags the last allowed cycle.
module mem_timeout_counter #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // done fires during the MAX_WAIT-th un-acknowledged cycle, so the request
  // is dropped on the edge that ends that cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign done = enable && !clear && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: pass-through for ALU ops, stalling handshake with data memory for loads/stores.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int unsigned DW       = DEFAULT_DW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memRead_MEM,
  input  logic             memWrite_MEM,
  input  logic             memToReg_MEM,
  input  logic             branchLink_MEM,
  input  logic             RegWrite_MEM,
  input  logic [REG_W-1:0] targetReg_MEM,
  input  logic [DW-1:0]    addr_MEM,
  input  logic [DW-1:0]    wdata_MEM,
  output logic             dm_req,
  output logic             dm_we,
  output logic [DW-1:0]    dm_addr,
  output logic [DW-1:0]    dm_wdata,
  input  logic             dm_ack,
  input  logic [DW-1:0]    dm_rdata,
  output logic             stall_MEM,
  output logic             valid_WB,
  output logic             RegWrite_WB,
  output logic             memToReg_WB,
  output logic             branchLink_WB,
  output logic [REG_W-1:0] targetReg_WB,
  output logic [DW-1:0]    result_WB,
  output logic [DW-1:0]    rdata_WB,
  output logic             fault_WB
);

  state_e state_q, state_d;

  // Operation latched on entry to ACCESS.
  logic             lat_rd_q, lat_rd_d;
  logic             lat_wr_q, lat_wr_d;
  logic             lat_m2r_q, lat_m2r_d;
  logic             lat_bl_q, lat_bl_d;
  logic             lat_rw_q, lat_rw_d;
  logic [REG_W-1:0] lat_tr_q, lat_tr_d;
  logic [DW-1:0]    lat_addr_q, lat_addr_d;
  logic [DW-1:0]    lat_wdata_q, lat_wdata_d;

  logic             dm_req_q, dm_req_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;
  logic             rw_q, rw_d;
  logic             m2r_q, m2r_d;
  logic             bl_q, bl_d;
  logic [REG_W-1:0] tr_q, tr_d;
  logic [DW-1:0]    result_q, result_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  logic is_mem;
  logic bad_op;
  logic to_done;

  assign is_mem = memRead_MEM || memWrite_MEM;
  assign bad_op = (memRead_MEM && memWrite_MEM) || ((addr_MEM[2:0] & ALIGN_MASK) != 3'b000);

  mem_timeout_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (state_q != S_ACCESS),
    .enable((state_q == S_ACCESS) && !dm_ack),
    .done  (to_done)
  );

  always_comb begin
    state_d     = state_q;
    lat_rd_d    = lat_rd_q;
    lat_wr_d    = lat_wr_q;
    lat_m2r_d   = lat_m2r_q;
    lat_bl_d    = lat_bl_q;
    lat_rw_d    = lat_rw_q;
    lat_tr_d    = lat_tr_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    dm_req_d    = 1'b0;
    valid_d     = 1'b0;
    fault_d     = 1'b0;
    rw_d        = rw_q;
    m2r_d       = m2r_q;
    bl_d        = bl_q;
    tr_d        = tr_q;
    result_d    = result_q;
    rdata_d     = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        m2r_d    = memToReg_MEM;
        bl_d     = branchLink_MEM;
        tr_d     = targetReg_MEM;
        result_d = addr_MEM;
        if (!is_mem) begin
          valid_d = 1'b1;
          rw_d    = RegWrite_MEM;
        end else if (bad_op) begin
          state_d = S_FAULT;
          valid_d = 1'b1;
          fault_d = 1'b1;
          rw_d    = 1'b0;
        end else begin
          state_d     = S_ACCESS;
          dm_req_d    = 1'b1;
          lat_rd_d    = memRead_MEM;
          lat_wr_d    = memWrite_MEM;
          lat_m2r_d   = memToReg_MEM;
          lat_bl_d    = branchLink_MEM;
          lat_rw_d    = RegWrite_MEM;
          lat_tr_d    = targetReg_MEM;
          lat_addr_d  = addr_MEM;
          lat_wdata_d = wdata_MEM;
          // WB fields keep their old values until the access completes.
          m2r_d       = m2r_q;
          bl_d        = bl_q;
          tr_d        = tr_q;
          result_d    = result_q;
        end
      end
      S_ACCESS: begin
        if (dm_ack || to_done) begin
          valid_d  = 1'b1;
          m2r_d    = lat_m2r_q;
          bl_d     = lat_bl_q;
          tr_d     = lat_tr_q;
          result_d = lat_addr_q;
          if (dm_ack) begin
            state_d = S_DONE;
            rw_d    = lat_rw_q;
            if (lat_rd_q) begin
              rdata_d = dm_rdata;
            end
          end else begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            rw_d    = 1'b0;
          end
        end else begin
          dm_req_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and all output registers; every register clears on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      lat_rd_q    <= 1'b0;
      lat_wr_q    <= 1'b0;
      lat_m2r_q   <= 1'b0;
      lat_bl_q    <= 1'b0;
      lat_rw_q    <= 1'b0;
      lat_tr_q    <= '0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      dm_req_q    <= 1'b0;
      valid_q     <= 1'b0;
      fault_q     <= 1'b0;
      rw_q        <= 1'b0;
      m2r_q       <= 1'b0;
      bl_q        <= 1'b0;
      tr_q        <= '0;
      result_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      lat_rd_q    <= lat_rd_d;
      lat_wr_q    <= lat_wr_d;
      lat_m2r_q   <= lat_m2r_d;
      lat_bl_q    <= lat_bl_d;
      lat_rw_q    <= lat_rw_d;
      lat_tr_q    <= lat_tr_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      dm_req_q    <= dm_req_d;
      valid_q     <= valid_d;
      fault_q     <= fault_d;
      rw_q        <= rw_d;
      m2r_q       <= m2r_d;
      bl_q        <= bl_d;
      tr_q        <= tr_d;
      result_q    <= result_d;
      rdata_q     <= rdata_d;
    end
  end

  assign stall_MEM = reset && (((state_q == S_IDLE) && is_mem) || (state_q == S_ACCESS));

  assign dm_req        = dm_req_q;
  assign dm_we         = dm_req_q && lat_wr_q;
  assign dm_addr       = lat_addr_q;
  assign dm_wdata      = lat_wdata_q;
  assign valid_WB      = valid_q;
  assign fault_WB      = fault_q;
  assign RegWrite_WB   = rw_q;
  assign memToReg_WB   = m2r_q;
  assign branchLink_WB = bl_q;
  assign targetReg_WB  = tr_q;
  assign result_WB     = result_q;
  assign rdata_WB      = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          memRead_MEM, memWrite_MEM, memToReg_MEM, branchLink_MEM, RegWrite_MEM;
  logic [4:0]    targetReg_MEM;
  logic [DW-1:0] addr_MEM, wdata_MEM;
  logic          dm_req, dm_we;
  logic [DW-1:0] dm_addr, dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          stall_MEM;
  logic          valid_WB, RegWrite_WB, memToReg_WB, branchLink_WB;
  logic [4:0]    targetReg_WB;
  logic [DW-1:0] result_WB, rdata_WB;
  logic          fault_WB;

  int nvec = 0;
  int nerr = 0;

  mem_access_unit #(
    .MAX_WAIT(16),
    .DW      (DW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .memRead_MEM   (memRead_MEM),
    .memWrite_MEM  (memWrite_MEM),
    .memToReg_MEM  (memToReg_MEM),
    .branchLink_MEM(branchLink_MEM),
    .RegWrite_MEM  (RegWrite_MEM),
    .targetReg_MEM (targetReg_MEM),
    .addr_MEM      (addr_MEM),
    .wdata_MEM     (wdata_MEM),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_ack        (dm_ack),
    .dm_rdata      (dm_rdata),
    .stall_MEM     (stall_MEM),
    .valid_WB      (valid_WB),
    .RegWrite_WB   (RegWrite_WB),
    .memToReg_WB   (memToReg_WB),
    .branchLink_WB (branchLink_WB),
    .targetReg_WB  (targetReg_WB),
    .result_WB     (result_WB),
    .rdata_WB      (rdata_WB),
    .fault_WB      (fault_WB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    memRead_MEM    = 1'b0;
    memWrite_MEM   = 1'b0;
    memToReg_MEM   = 1'b0;
    branchLink_MEM = 1'b0;
    RegWrite_MEM   = 1'b0;
    targetReg_MEM  = '0;
    addr_MEM       = '0;
    wdata_MEM      = '0;
    dm_ack         = 1'b0;
    dm_rdata       = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    bubble();
    reset = 1'b0;
    memRead_MEM = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_stall", stall_MEM, 1'b0);
    chk("rst_dm_req", dm_req, 1'b0);
    chk("rst_valid", valid_WB, 1'b0);
    chk("rst_fault", fault_WB, 1'b0);
    chk("rst_rdata", rdata_WB, 64'd0);
    chk("rst_result", result_WB, 64'd0);

    // ALU pass-through
    next_cycle();
    reset = 1'b1;
    bubble();
    RegWrite_MEM = 1'b1;
    targetReg_MEM = 5'd20;
    addr_MEM = 64'd420;
    @(negedge clk);
    chk("alu_stall0", stall_MEM, 1'b0);
    next_cycle();
    bubble();
    @(negedge clk);
    chk("alu_valid", valid_WB, 1'b1);
    chk("alu_result", result_WB, 64'd420);
    chk("alu_treg", targetReg_WB, 5'd20);
    chk("alu_regwrite", RegWrite_WB, 1'b1);
    chk("alu_stall1", stall_MEM, 1'b0);
    chk("alu_no_req", dm_req, 1'b0);

    // Load 0x40, ack in first ACCESS cycle
    next_cycle();
    memRead_MEM = 1'b1;
    memToReg_MEM = 1'b1;
    RegWrite_MEM = 1'b1;
    targetReg_MEM = 5'd5;
    addr_MEM = 64'h40;
    @(negedge clk);
    chk("ld_stall_idle", stall_MEM, 1'b1);
    chk("ld_no_req_idle", dm_req, 1'b0);
    next_cycle();
    dm_ack = 1'b1;
    dm_rdata = 64'd42069;
    @(negedge clk);
    chk("ld_req", dm_req, 1'b1);
    chk("ld_addr", dm_addr, 64'h40);
    chk("ld_we", dm_we, 1'b0);
    chk("ld_stall_acc", stall_MEM, 1'b1);
    next_cycle();
    dm_ack = 1'b0;
    @(negedge clk);
    chk("ld_done_valid", valid_WB, 1'b1);
    chk("ld_done_rdata", rdata_WB, 64'd42069);
    chk("ld_done_result", result_WB, 64'h40);
    chk("ld_done_treg", targetReg_WB, 5'd5);
    chk("ld_done_m2r", memToReg_WB, 1'b1);
    chk("ld_done_rw", RegWrite_WB, 1'b1);
    chk("ld_done_stall", stall_MEM, 1'b0);
    chk("ld_done_req", dm_req, 1'b0);
    chk("ld_done_fault", fault_WB, 1'b0);
    next_cycle();
    bubble();
    @(negedge clk);
    chk("ld_after_valid", valid_WB, 1'b0);
    chk("ld_after_req", dm_req, 1'b0);

    // Store 0x80, ack on the 5th ACCESS cycle; inputs perturbed to prove latching
    next_cycle();
    memWrite_MEM = 1'b1;
    addr_MEM = 64'h80;
    wdata_MEM = 64'd69;
    @(negedge clk);
    chk("st_stall_idle", stall_MEM, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      next_cycle();
      wdata_MEM = 64'd123;
      addr_MEM = 64'h88;
      if (i == 5) begin
        dm_ack = 1'b1;
        dm_rdata = 64'hDEAD;
      end
      @(negedge clk);
      chk("st_req", dm_req, 1'b1);
      chk("st_we", dm_we, 1'b1);
      chk("st_wdata", dm_wdata, 64'd69);
      chk("st_addr", dm_addr, 64'h80);
      chk("st_stall", stall_MEM, 1'b1);
    end
    next_cycle();
    dm_ack = 1'b0;
    wdata_MEM = 64'd69;
    addr_MEM = 64'h80;
    @(negedge clk);
    chk("st_done_valid", valid_WB, 1'b1);
    chk("st_done_rdata_kept", rdata_WB, 64'd42069);
    chk("st_done_result", result_WB, 64'h80);
    chk("st_done_stall", stall_MEM, 1'b0);
    chk("st_done_req", dm_req, 1'b0);
    next_cycle();
    bubble();
    @(negedge clk);
    chk("st_noreissue_req", dm_req, 1'b0);
    chk("st_single_done", valid_WB, 1'b0);

    // Misaligned load
    next_cycle();
    memRead_MEM = 1'b1;
    RegWrite_MEM = 1'b1;
    addr_MEM = 64'h43;
    @(negedge clk);
    chk("mis_stall", stall_MEM, 1'b1);
    chk("mis_no_req0", dm_req, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("mis_fault", fault_WB, 1'b1);
    chk("mis_valid", valid_WB, 1'b1);
    chk("mis_rw", RegWrite_WB, 1'b0);
    chk("mis_no_req1", dm_req, 1'b0);
    chk("mis_stall_f", stall_MEM, 1'b0);
    next_cycle();
    bubble();
    @(negedge clk);
    chk("mis_fault_pulse", fault_WB, 1'b0);

    // Read and write together is illegal even when aligned
    next_cycle();
    memRead_MEM = 1'b1;
    memWrite_MEM = 1'b1;
    addr_MEM = 64'h10;
    next_cycle();
    @(negedge clk);
    chk("rw_fault", fault_WB, 1'b1);
    chk("rw_no_req", dm_req, 1'b0);
    next_cycle();
    bubble();

    // Timeout: never acknowledged
    next_cycle();
    memRead_MEM = 1'b1;
    RegWrite_MEM = 1'b1;
    addr_MEM = 64'h100;
    n = 0;
    next_cycle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!dm_req) break;
      n++;
      next_cycle();
    end
    chk("to_req_cycles", n, 16);
    chk("to_fault", fault_WB, 1'b1);
    chk("to_valid", valid_WB, 1'b1);
    chk("to_rw", RegWrite_WB, 1'b0);
    chk("to_stall", stall_MEM, 1'b0);
    next_cycle();
    bubble();

    // Reset during the 3rd ACCESS cycle
    next_cycle();
    memRead_MEM = 1'b1;
    RegWrite_MEM = 1'b1;
    addr_MEM = 64'h200;
    next_cycle();
    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rm_req_still", dm_req, 1'b1);
    chk("rm_stall_rst", stall_MEM, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("rm_req", dm_req, 1'b0);
    chk("rm_valid", valid_WB, 1'b0);
    chk("rm_fault", fault_WB, 1'b0);
    chk("rm_rdata", rdata_WB, 64'd0);
    chk("rm_result", result_WB, 64'd0);
    next_cycle();
    reset = 1'b1;
    bubble();
    memRead_MEM = 1'b1;
    RegWrite_MEM = 1'b1;
    targetReg_MEM = 5'd9;
    addr_MEM = 64'h48;
    @(negedge clk);
    chk("rm_new_stall", stall_MEM, 1'b1);
    next_cycle();
    dm_ack = 1'b1;
    dm_rdata = 64'd777;
    @(negedge clk);
    chk("rm_new_req", dm_req, 1'b1);
    chk("rm_new_addr", dm_addr, 64'h48);
    next_cycle();
    dm_ack = 1'b0;
    @(negedge clk);
    chk("rm_new_valid", valid_WB, 1'b1);
    chk("rm_new_rdata", rdata_WB, 64'd777);
    chk("rm_new_treg", targetReg_WB, 5'd9);
    chk("rm_new_fault", fault_WB, 1'b0);
    next_cycle();
    bubble();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
